// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: sequencer for an N-stage register pipeline.
// Tracks one valid token per stage, drives per-stage load enables, collapses
// bubbles, propagates backpressure and performs an in-order flush/drain.
// Optional feature macro: PIPE_SEQ_STATS_EN (output-stall cycle counter).
module pipe_seq_ctrl #(
    parameter int STAGES = 4,
    parameter int OCC_W  = $clog2(STAGES + 1),
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_vld,
    output logic [OCC_W-1:0]  occupancy,
    output logic              busy,
    output logic              flush_done,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] ld;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic              flush_done_q;
    logic              accept;
    logic              emit;

    // Ready chain: stage i may load unless it and every stage after it are
    // full while the output is stalled (flattened form of the ripple chain).
    always_comb begin
        logic [STAGES-1:0] m;
        ld = '0;
        for (int i = 0; i < STAGES; i++) begin
            m     = {STAGES{1'b1}} << i;
            ld[i] = out_ready | ~(&(v_q | ~m));
        end
    end

    assign in_ready   = ld[0] & (state_q != DRAIN) & (state_q != DONE);
    assign accept     = in_valid & in_ready;
    assign emit       = v_q[STAGES-1] & out_ready;
    assign occ_d      = occ_q + {{(OCC_W-1){1'b0}}, accept} - {{(OCC_W-1){1'b0}}, emit};

    assign stage_en   = ld;
    assign stage_vld  = v_q;
    assign out_valid  = v_q[STAGES-1];
    assign occupancy  = occ_q;
    assign busy       = (state_q != IDLE);
    assign flush_done = flush_done_q;

    // Valid tokens advance into every stage whose load enable is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            if (ld[0]) v_q[0] <= accept;
            for (int i = 1; i < STAGES; i++) begin
                if (ld[i]) v_q[i] <= v_q[i-1];
            end
        end
    end

    // Control FSM with occupancy tracking; flush_done is high exactly in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            occ_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        // A token accepted alongside the flush must still drain out.
                        if (accept) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q      <= DONE;
                            flush_done_q <= 1'b1;
                        end
                    end else if (accept) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q <= DRAIN;
                    end else if (occ_d == '0) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (occ_d == '0) begin
                        state_q      <= DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef PIPE_SEQ_STATS_EN
    logic [STAT_W-1:0] stall_q;

    // Count cycles where the last stage holds a token that is not consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (flush_done_q) begin
            stall_q <= '0;
        end else if (v_q[STAGES-1] && !out_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
